edge_result_writer: RTL

- Write-side counterpart of the 3-row line-BRAM reader in the edge-detection datapath.
- Accepts clamped 8-bit edge pixels in raster order over a valid/ready handshake.
- Packs three pixels into one 24-bit word, using the same lane layout as the row BRAMs.
- Drives a simple BRAM write port and raises a sticky done once a full frame (or a last-flagged partial) has been stored.

---
 rtl/edge_pkg.sv | 25 ++
 rtl/edge_result_writer_if.sv | 17 +
 rtl/edge_pixel_packer.sv | 49 ++++
 rtl/edge_result_writer.sv | 133 +++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection result writer.
// Holds pixel/word geometry, frame size, the writer FSM state type, the lane
// index type and a helper that places a pixel into its lane of a BRAM word.
package edge_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned LANES       = 3;
    localparam int unsigned WORD_W      = LANES * PIX_W;
    localparam int unsigned ADDR_W      = 16;
    localparam int unsigned FRAME_WORDS = 64518;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef logic [$clog2(LANES)-1:0] lane_t;

    // Lane 0 occupies the most significant byte, matching the row BRAM layout.
    function automatic logic [WORD_W-1:0] place_lane(input lane_t lane,
                                                      input logic [PIX_W-1:0] pix);
        logic [WORD_W-1:0] w;
        w            = '0;
        w[PIX_W-1:0] = pix;
        return w << (PIX_W * (LANES - 1 - int'(lane)));
    endfunction

endpackage

// File: rtl/edge_result_writer_if.sv
// Pixel stream interface into the edge result writer.
//   in_valid : pixel valid (source)
//   in_ready : writer can accept (sink)
//   in_data  : pixel value (source)
//   in_last  : final pixel of the frame, qualified by in_valid (source)
// master = pixel source, slave = writer.
interface edge_result_writer_if import edge_pkg::*; ();

    logic             in_valid;
    logic             in_ready;
    logic [PIX_W-1:0] in_data;
    logic             in_last;

    modport master (output in_valid, output in_data, output in_last, input in_ready);
    modport slave  (input in_valid, input in_data, input in_last, output in_ready);

endinterface

// File: rtl/edge_pixel_packer.sv
// Packs accepted pixels into BRAM words, lane 0 in the top byte.
// Ports:
//   clka, rst  : clock, async active-high reset
//   clear      : drop any partial word and restart at lane 0
//   accept     : a pixel is taken this cycle
//   pix        : pixel value to place
//   last       : the accepted pixel closes the word early
//   word       : packed word including this cycle's pixel (unfilled lanes zero)
//   word_valid : this accept completes a word
module edge_pixel_packer import edge_pkg::*; (
    input  logic              clka,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [PIX_W-1:0]  pix,
    input  logic              last,
    output logic [WORD_W-1:0] word,
    output logic              word_valid
);

    lane_t             lane_q, lane_d;
    logic [WORD_W-1:0] pack_q, pack_d;

    assign word       = pack_q | place_lane(lane_q, pix);
    assign word_valid = accept && ((lane_q == lane_t'(LANES - 1)) || last);

    always_comb begin
        lane_d = lane_q;
        pack_d = pack_q;
        if (clear || word_valid) begin
            lane_d = '0;
            pack_d = '0;
        end else if (accept) begin
            lane_d = lane_q + 1'b1;
            pack_d = word;
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            lane_q <= '0;
            pack_q <= '0;
        end else begin
            lane_q <= lane_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/edge_result_writer.sv
// Writes edge pixels into a frame BRAM, three pixels per word.
// Ports:
//   clka, rst     : clock, async active-high reset
//   start         : pulse; begins or restarts (aborts) a frame
//   pix           : pixel stream (slave modport of edge_result_writer_if)
//   thresh        : binarisation threshold, only with EDGE_WR_THRESH_EN defined
//   wea/addra/dina: BRAM write port, wea pulses one cycle per word
//   done          : sticky frame-stored flag, cleared by start or rst
//   words_written : words written in the current frame
// Optional feature macro: EDGE_WR_THRESH_EN (pixels stored as 8'hFF / 8'h00).
module edge_result_writer import edge_pkg::*; #(
    parameter int unsigned DEPTH = FRAME_WORDS
) (
    input  logic                clka,
    input  logic                rst,
    input  logic                start,
    edge_result_writer_if.slave pix,
`ifdef EDGE_WR_THRESH_EN
    input  logic [PIX_W-1:0]    thresh,
`endif
    output logic                wea,
    output logic [ADDR_W-1:0]   addra,
    output logic [WORD_W-1:0]   dina,
    output logic                done,
    output logic [ADDR_W-1:0]   words_written
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] word_addr_q, word_addr_d;
    logic [ADDR_W-1:0] words_q, words_d;
    logic [ADDR_W-1:0] addra_q, addra_d;
    logic [WORD_W-1:0] dina_q, dina_d;
    logic              wea_q, wea_d;
    // Final word of the frame is being written; no more pixels this frame.
    logic              fin_q, fin_d;

    logic              accept;
    logic              word_valid;
    logic              final_word;
    logic [WORD_W-1:0] word;
    logic [PIX_W-1:0]  pix_val;

`ifdef EDGE_WR_THRESH_EN
    assign pix_val = (pix.in_data >= thresh) ? '1 : '0;
`else
    assign pix_val = pix.in_data;
`endif

    assign pix.in_ready = (state_q == RUN) && !fin_q;
    // A pixel presented alongside start is dropped: start wins.
    assign accept       = pix.in_valid && pix.in_ready && !start;
    assign final_word   = pix.in_last || (word_addr_q == LastAddr);

    edge_pixel_packer u_packer (
        .clka       (clka),
        .rst        (rst),
        .clear      (start),
        .accept     (accept),
        .pix        (pix_val),
        .last       (pix.in_last),
        .word       (word),
        .word_valid (word_valid)
    );

    always_comb begin
        state_d     = state_q;
        word_addr_d = word_addr_q;
        words_d     = words_q;
        addra_d     = addra_q;
        dina_d      = dina_q;
        wea_d       = 1'b0;
        fin_d       = fin_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    word_addr_d = '0;
                    words_d     = '0;
                    fin_d       = 1'b0;
                end
            end
            RUN: begin
                if (start) begin
                    word_addr_d = '0;
                    words_d     = '0;
                    fin_d       = 1'b0;
                end else if (fin_q) begin
                    state_d = DONE;
                    fin_d   = 1'b0;
                end else if (word_valid) begin
                    wea_d       = 1'b1;
                    addra_d     = word_addr_q;
                    dina_d      = word;
                    words_d     = words_q + ADDR_W'(1);
                    fin_d       = final_word;
                    // Saturate so the address never steps past the frame.
                    word_addr_d = (word_addr_q == LastAddr) ? word_addr_q
                                                            : word_addr_q + ADDR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            words_q     <= '0;
            addra_q     <= '0;
            dina_q      <= '0;
            wea_q       <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_addr_q <= word_addr_d;
            words_q     <= words_d;
            addra_q     <= addra_d;
            dina_q      <= dina_d;
            wea_q       <= wea_d;
            fin_q       <= fin_d;
        end
    end

    assign wea           = wea_q;
    assign addra         = addra_q;
    assign dina          = dina_q;
    assign done          = (state_q == DONE);
    assign words_written = words_q;

endmodule
